rc_mesh: RTL and testbench
==========================

# rc_mesh

Parametrised route-compute stage for the 2D-mesh NoC router, instantiated once per input port between the input FIFO and the switch allocator. It replaces the fixed per-node route tables with coordinate arithmetic configured by parameters. It performs minimal adaptive routing driven by neighbour pressure and holds each packet's route for its whole length (wormhole). It also adds a valid/ready output handshake and protocol-error detection.

## Interface
- DATASIZE, 40, flit width. Fields: src[39:36], dst[35:32], timestamp[31:24], data[23:2], type[1:0].
- DST_LSB, 32, LSB of dst field; dst x = dst[DST_LSB+X_BITS-1:DST_LSB], dst y = next Y_BITS bits.
- X_BITS, 2, x-coordinate width.
- Y_BITS, 2, y-coordinate width.
- MESH_X, 3, number of mesh columns.
- MESH_Y, 3, number of mesh rows.
- CUR_X, 0, this router's x coordinate.
- CUR_Y, 1, this router's y coordinate.
- WIDTH, 3, pressure inputs are WIDTH+1 bits.
- ADAPTIVE, 1, 1 = pressure-adaptive minimal routing; 0 = deterministic XY routing.
- CNT_W, 8, width of the error counter.
- rc_clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- data_in  in  DATASIZE  incoming flit.
- valid_in  in  1  data_in valid.
- ready_out  out  1  stage can accept a flit this cycle.
- N_pressure_in, E_pressure_in, S_pressure_in, W_pressure_in  in  WIDTH+1 each  neighbour occupancy; lower is better.
- data_out  out  DATASIZE  registered flit.
- direction_out  out  4  one-hot port: 1000 W, 0100 N, 0010 E, 0001 S, 0000 local, 1111 no route.
- valid_out  out  1  data_out/direction_out valid.
- rc_ready  in  1  downstream accepts the flit this cycle.
- err_out  out  1  flag carried with the current output flit.
- err_cnt  out  CNT_W  saturating count of erroneous flits.

## Operation
- Flit type: 01 head, 00 body, 10 tail, 11 single (head and tail).
- Route calculation for head and single flits:
  - dx = dst_x vs CUR_X; dy = dst_y vs CUR_Y.
  - Larger x gives E; smaller x gives W. Larger y gives S; smaller y gives N.
  - dx = dy = 0 gives 0000 (local).
  - Only one axis differs: take that axis's direction.
  - Both axes differ, ADAPTIVE=1: take the x direction if P_x <= P_y (a tie goes to x); otherwise take the y direction.
  - Both axes differ, ADAPTIVE=0: always take the x direction.
  - dst_x >= MESH_X or dst_y >= MESH_Y: direction 1111 and error.
- Wormhole FSM with states IDLE and LOCKED. Register locked_dir.
- IDLE transitions:
  - head: compute route, load locked_dir, go to LOCKED. A head with error (1111) stays IDLE.
  - single: compute route, stay IDLE.
  - body or tail: direction 1111, error, stay IDLE.
- LOCKED transitions:
  - body: output locked_dir, stay LOCKED.
  - tail: output locked_dir, go to IDLE.
  - head: error; recompute the route and relock (stay LOCKED, or go IDLE if the result is 1111).
  - single: error; recompute the route, go to IDLE.
- FSM, locked_dir and err_cnt update only on an accepted flit.
- err_cnt increments by 1 per accepted erroneous flit and saturates at all-ones.
- Erroneous flits are still forwarded; downstream discards direction 1111.

## Timing
- Reset values: data_out 0, direction_out 1111, valid_out 0, err_out 0, err_cnt 0, state IDLE, locked_dir 1111.
- ready_out = !valid_out || rc_ready (combinational).
- A flit is accepted when valid_in && ready_out.
- Accept at cycle t: data_out, direction_out and err_out are registered and valid_out=1 at t+1. Latency 1; full throughput while rc_ready=1.
- Pressures are sampled only in the accept cycle. Later pressure changes never alter a held output.
- valid_out && !rc_ready: all outputs hold, ready_out=0, and no state changes.
- Output consumed with no new accept: valid_out goes to 0. direction_out goes to 1111 and data_out holds.
- Reset mid-packet: immediate return to IDLE. Following body/tail flits are errors.

## Structure
- Shared package rc_pkg holds:
  - direction constants (DIR_W, DIR_N, DIR_E, DIR_S, DIR_LOCAL, DIR_NONE);
  - flit-type constants;
  - flit field LSB/MSB constants.
- Sub-module rc_route_calc: the combinational route decision (coordinates, pressures, ADAPTIVE) producing dir and range_err. The top level holds the FSM, handshake register and counter.

## Test plan
All scenarios use default parameters (node x=0, y=1).
- Route selection by pressure:
  - Single to dst 4'b0010 (x=2, y=0) with E=2, N=5 -> direction_out 0010, valid_out high 1 cycle later.
  - Repeat with E=6, N=5 -> 0100.
  - Repeat with E=N=4 -> 0010.
- Local delivery: single to dst 4'b0100 -> direction_out 0000, err_out 0.
- Wormhole lock: head to dst 4'b1010 with E=1, S=7 -> 0010. Then body and tail with E=7, S=0 -> both 0010. The next single to 4'b1000 -> 0001.
- Backpressure: hold rc_ready=0 for 3 cycles with valid_out=1 -> ready_out=0, outputs stable, err_cnt unchanged. Then rc_ready=1 -> next flit lands the following cycle.
- Errors:
  - dst 4'b0011 (x=3 out of range) -> 1111, err_out=1, err_cnt=1.
  - Body flit in IDLE -> 1111, err_cnt=2.
  - 260 errors -> err_cnt=255.
- Reset mid-packet: assert rst_n low after a head. On release, a tail flit -> 1111, err_out=1, state IDLE.

Source files
------------

// File: rtl/rc_pkg.sv
// rtl/rc_pkg.sv - shared direction, flit-type and field constants for the mesh route-compute stage
package rc_pkg;

   localparam logic [3:0] DIR_W     = 4'b1000;
   localparam logic [3:0] DIR_N     = 4'b0100;
   localparam logic [3:0] DIR_E     = 4'b0010;
   localparam logic [3:0] DIR_S     = 4'b0001;
   localparam logic [3:0] DIR_LOCAL = 4'b0000;
   localparam logic [3:0] DIR_NONE  = 4'b1111;

   localparam logic [1:0] FLIT_BODY   = 2'b00;
   localparam logic [1:0] FLIT_HEAD   = 2'b01;
   localparam logic [1:0] FLIT_TAIL   = 2'b10;
   localparam logic [1:0] FLIT_SINGLE = 2'b11;

   localparam int TYPE_LSB = 0;
   localparam int TYPE_MSB = 1;
   localparam int DATA_LSB = 2;
   localparam int DATA_MSB = 23;
   localparam int TS_LSB   = 24;
   localparam int TS_MSB   = 31;
   localparam int DST_LSB0 = 32;
   localparam int DST_MSB  = 35;
   localparam int SRC_LSB  = 36;
   localparam int SRC_MSB  = 39;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } rc_state_t;

endpackage

// File: rtl/rc_route_calc.sv
// rtl/rc_route_calc.sv - combinational minimal route decision from destination coordinates and neighbour pressure
module rc_route_calc
   import rc_pkg::*;
#(
   parameter int X_BITS   = 2,
   parameter int Y_BITS   = 2,
   parameter int MESH_X   = 3,
   parameter int MESH_Y   = 3,
   parameter int CUR_X    = 0,
   parameter int CUR_Y    = 1,
   parameter int WIDTH    = 3,
   parameter int ADAPTIVE = 1
)
(
   input  logic [X_BITS-1:0] dst_x,
   input  logic [Y_BITS-1:0] dst_y,
   input  logic [WIDTH:0]    n_pressure,
   input  logic [WIDTH:0]    e_pressure,
   input  logic [WIDTH:0]    s_pressure,
   input  logic [WIDTH:0]    w_pressure,
   output logic [3:0]        dir,
   output logic              range_err
);

   localparam logic [X_BITS:0]   LIMIT_X = (X_BITS+1)'(MESH_X);
   localparam logic [Y_BITS:0]   LIMIT_Y = (Y_BITS+1)'(MESH_Y);
   localparam logic [X_BITS-1:0] HOME_X  = X_BITS'(CUR_X);
   localparam logic [Y_BITS-1:0] HOME_Y  = Y_BITS'(CUR_Y);

   logic             x_diff;
   logic             y_diff;
   logic [3:0]       x_dir;
   logic [3:0]       y_dir;
   logic [WIDTH:0]   x_p;
   logic [WIDTH:0]   y_p;

   always_comb begin
      x_diff    = (dst_x != HOME_X);
      y_diff    = (dst_y != HOME_Y);
      x_dir     = (dst_x > HOME_X) ? DIR_E : DIR_W;
      x_p       = (dst_x > HOME_X) ? e_pressure : w_pressure;
      y_dir     = (dst_y > HOME_Y) ? DIR_S : DIR_N;
      y_p       = (dst_y > HOME_Y) ? s_pressure : n_pressure;
      range_err = ({1'b0, dst_x} >= LIMIT_X) || ({1'b0, dst_y} >= LIMIT_Y);

      // Both axes open: pressure picks the hop, a tie favours x so routing stays XY-like.
      if (range_err)
         dir = DIR_NONE;
      else if (!x_diff && !y_diff)
         dir = DIR_LOCAL;
      else if (!y_diff)
         dir = x_dir;
      else if (!x_diff)
         dir = y_dir;
      else if ((ADAPTIVE == 0) || (x_p <= y_p))
         dir = x_dir;
      else
         dir = y_dir;
   end

endmodule

// File: rtl/rc_mesh.sv
// rtl/rc_mesh.sv - wormhole route-compute stage with valid/ready output register and error counting
module rc_mesh
   import rc_pkg::*;
#(
   parameter int DATASIZE = 40,
   parameter int DST_LSB  = 32,
   parameter int X_BITS   = 2,
   parameter int Y_BITS   = 2,
   parameter int MESH_X   = 3,
   parameter int MESH_Y   = 3,
   parameter int CUR_X    = 0,
   parameter int CUR_Y    = 1,
   parameter int WIDTH    = 3,
   parameter int ADAPTIVE = 1,
   parameter int CNT_W    = 8
)
(
   input  logic                rc_clk,
   input  logic                rst_n,
   input  logic [DATASIZE-1:0] data_in,
   input  logic                valid_in,
   output logic                ready_out,
   input  logic [WIDTH:0]      N_pressure_in,
   input  logic [WIDTH:0]      E_pressure_in,
   input  logic [WIDTH:0]      S_pressure_in,
   input  logic [WIDTH:0]      W_pressure_in,
   output logic [DATASIZE-1:0] data_out,
   output logic [3:0]          direction_out,
   output logic                valid_out,
   input  logic                rc_ready,
   output logic                err_out,
   output logic [CNT_W-1:0]    err_cnt
);

   rc_state_t  state;
   logic [3:0] locked_dir;
   logic [1:0] flit_type;
   logic [3:0] route_dir;
   logic       range_err;
   logic [3:0] flit_dir;
   logic       flit_err;
   logic       accept;

   assign flit_type = data_in[TYPE_MSB:TYPE_LSB];
   assign ready_out = !valid_out || rc_ready;
   assign accept    = valid_in && ready_out;

   rc_route_calc #(
      .X_BITS   (X_BITS),
      .Y_BITS   (Y_BITS),
      .MESH_X   (MESH_X),
      .MESH_Y   (MESH_Y),
      .CUR_X    (CUR_X),
      .CUR_Y    (CUR_Y),
      .WIDTH    (WIDTH),
      .ADAPTIVE (ADAPTIVE)
   ) u_route_calc (
      .dst_x      (data_in[DST_LSB +: X_BITS]),
      .dst_y      (data_in[DST_LSB+X_BITS +: Y_BITS]),
      .n_pressure (N_pressure_in),
      .e_pressure (E_pressure_in),
      .s_pressure (S_pressure_in),
      .w_pressure (W_pressure_in),
      .dir        (route_dir),
      .range_err  (range_err)
   );

   // Direction and error flag the accepted flit will carry.
   always_comb begin
      flit_dir = route_dir;
      flit_err = range_err;
      case (flit_type)
         FLIT_HEAD, FLIT_SINGLE: begin
            if (state == ST_LOCKED)
               flit_err = 1'b1;
         end
         default: begin
            if (state == ST_LOCKED) begin
               flit_dir = locked_dir;
               flit_err = 1'b0;
            end else begin
               flit_dir = DIR_NONE;
               flit_err = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge rc_clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         locked_dir    <= DIR_NONE;
         data_out      <= '0;
         direction_out <= DIR_NONE;
         valid_out     <= 1'b0;
         err_out       <= 1'b0;
         err_cnt       <= '0;
      end else if (accept) begin
         data_out      <= data_in;
         direction_out <= flit_dir;
         err_out       <= flit_err;
         valid_out     <= 1'b1;
         if (flit_err && (err_cnt != '1))
            err_cnt <= err_cnt + 1'b1;
         case (state)
            ST_IDLE: begin
               if ((flit_type == FLIT_HEAD) && !range_err) begin
                  state      <= ST_LOCKED;
                  locked_dir <= route_dir;
               end
            end
            ST_LOCKED: begin
               case (flit_type)
                  FLIT_BODY: ;
                  FLIT_HEAD: begin
                     // A stray head restarts the worm unless its own route is unusable.
                     if (range_err)
                        state <= ST_IDLE;
                     else
                        locked_dir <= route_dir;
                  end
                  default: state <= ST_IDLE;
               endcase
            end
            default: state <= ST_IDLE;
         endcase
      end else if (valid_out && rc_ready) begin
         valid_out     <= 1'b0;
         direction_out <= DIR_NONE;
         err_out       <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rc_mesh.sv
// tb/tb_rc_mesh.sv - randomized and directed checks of rc_mesh against a packet-level reference model
module tb_rc_mesh;

   localparam int CX = 0;
   localparam int CY = 1;
   localparam logic [1:0] T_BODY = 2'b00, T_HEAD = 2'b01, T_TAIL = 2'b10, T_SINGLE = 2'b11;

   logic        rc_clk = 1'b0;
   logic        rst_n;
   logic [39:0] data_in;
   logic        valid_in;
   logic        ready_out;
   logic [3:0]  N_pressure_in, E_pressure_in, S_pressure_in, W_pressure_in;
   logic [39:0] data_out;
   logic [3:0]  direction_out;
   logic        valid_out;
   logic        rc_ready;
   logic        err_out;
   logic [7:0]  err_cnt;

   rc_mesh dut (
      .rc_clk        (rc_clk),
      .rst_n         (rst_n),
      .data_in       (data_in),
      .valid_in      (valid_in),
      .ready_out     (ready_out),
      .N_pressure_in (N_pressure_in),
      .E_pressure_in (E_pressure_in),
      .S_pressure_in (S_pressure_in),
      .W_pressure_in (W_pressure_in),
      .data_out      (data_out),
      .direction_out (direction_out),
      .valid_out     (valid_out),
      .rc_ready      (rc_ready),
      .err_out       (err_out),
      .err_cnt       (err_cnt)
   );

   always #5 rc_clk = ~rc_clk;

   int checks = 0;
   int failures = 0;

   // Reference model: what the output register must hold, plus whether a packet is open.
   bit          m_valid;
   logic [39:0] m_data;
   logic [3:0]  m_dir;
   bit          m_err;
   int          m_cnt;
   bit          m_in_pkt;
   logic [3:0]  m_pkt_dir;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] model_route(input logic [3:0] dst, input int pn, input int pe,
                                               input int ps, input int pw, output bit bad);
      int x;
      int y;
      logic [3:0] xd;
      logic [3:0] yd;
      int px;
      int py;
      x   = int'(dst[1:0]);
      y   = int'(dst[3:2]);
      bad = (x >= 3) || (y >= 3);
      if (bad) return 4'b1111;
      xd = (x > CX) ? 4'b0010 : 4'b1000;
      px = (x > CX) ? pe : pw;
      yd = (y > CY) ? 4'b0001 : 4'b0100;
      py = (y > CY) ? ps : pn;
      if (x == CX && y == CY) return 4'b0000;
      if (x == CX) return yd;
      if (y == CY) return xd;
      return (px <= py) ? xd : yd;
   endfunction

   function automatic logic [39:0] mk(input logic [1:0] t, input logic [3:0] dst);
      logic [3:0]  src = 4'($urandom);
      logic [7:0]  ts  = 8'($urandom);
      logic [21:0] pl  = 22'($urandom);
      return {src, dst, ts, pl, t};
   endfunction

   task automatic model_reset();
      m_valid = 0; m_data = '0; m_dir = 4'b1111; m_err = 0; m_cnt = 0;
      m_in_pkt = 0; m_pkt_dir = 4'b1111;
   endtask

   task automatic compare_outputs();
      check("valid_out", valid_out, m_valid);
      check("err_cnt", err_cnt, m_cnt);
      if (m_valid) begin
         check("data_out", data_out, m_data);
         check("direction_out", direction_out, m_dir);
         check("err_out", err_out, m_err);
      end else begin
         check("idle_direction", direction_out, 4'b1111);
      end
   endtask

   // One clock: drive at the falling edge, predict, compare at the next falling edge.
   task automatic step(input logic [39:0] f, input bit vin, input bit rdy,
                       input logic [3:0] n, input logic [3:0] e, input logic [3:0] s, input logic [3:0] w);
      bit         acc;
      bit         bad;
      logic [3:0] r;
      logic [3:0] d;
      bit         er;
      data_in = f; valid_in = vin; rc_ready = rdy;
      N_pressure_in = n; E_pressure_in = e; S_pressure_in = s; W_pressure_in = w;
      #1;
      check("ready_out", ready_out, !m_valid || rdy);
      acc = vin && (!m_valid || rdy);
      if (acc) begin
         r = model_route(f[35:32], n, e, s, w, bad);
         d = r; er = bad;
         if (f[1:0] == T_HEAD) begin
            er = bad || m_in_pkt;
            m_in_pkt = !bad;
            if (!bad) m_pkt_dir = r;
         end else if (f[1:0] == T_SINGLE) begin
            er = bad || m_in_pkt;
            m_in_pkt = 0;
         end else begin
            d  = m_in_pkt ? m_pkt_dir : 4'b1111;
            er = !m_in_pkt;
            if (f[1:0] == T_TAIL) m_in_pkt = 0;
         end
         m_valid = 1; m_data = f; m_dir = d; m_err = er;
         if (er && m_cnt < 255) m_cnt++;
      end else if (m_valid && rdy) begin
         m_valid = 0; m_dir = 4'b1111;
      end
      @(negedge rc_clk);
      compare_outputs();
   endtask

   task automatic apply_reset();
      rst_n = 1'b0; valid_in = 1'b0;
      #1;
      model_reset();
      compare_outputs();
      check("reset_data_out", data_out, 40'h0);
      check("reset_err_out", err_out, 1'b0);
      @(negedge rc_clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; valid_in = 0; rc_ready = 1; data_in = '0;
      N_pressure_in = 0; E_pressure_in = 0; S_pressure_in = 0; W_pressure_in = 0;
      model_reset();
      @(negedge rc_clk);
      apply_reset();
      check("reset_ready_out", ready_out, 1'b1);

      // Pressure-driven choice between E and N towards (2,0).
      step(mk(T_SINGLE, 4'b0010), 1, 1, 4'd5, 4'd2, 4'd0, 4'd0);
      check("lit_e_lower", direction_out, 4'b0010);
      check("lit_valid_lat1", valid_out, 1'b1);
      step(mk(T_SINGLE, 4'b0010), 1, 1, 4'd5, 4'd6, 4'd0, 4'd0);
      check("lit_n_lower", direction_out, 4'b0100);
      step(mk(T_SINGLE, 4'b0010), 1, 1, 4'd4, 4'd4, 4'd0, 4'd0);
      check("lit_tie_x", direction_out, 4'b0010);
      step(mk(T_SINGLE, 4'b0100), 1, 1, 4'd0, 4'd0, 4'd0, 4'd0);
      check("lit_local", direction_out, 4'b0000);
      check("lit_local_err", err_out, 1'b0);

      // Wormhole lock survives a pressure swing.
      step(mk(T_HEAD, 4'b1010), 1, 1, 4'd0, 4'd1, 4'd7, 4'd0);
      check("lit_head", direction_out, 4'b0010);
      step(mk(T_BODY, 4'b0000), 1, 1, 4'd0, 4'd7, 4'd0, 4'd0);
      check("lit_body_locked", direction_out, 4'b0010);
      step(mk(T_TAIL, 4'b0000), 1, 1, 4'd0, 4'd7, 4'd0, 4'd0);
      check("lit_tail_locked", direction_out, 4'b0010);
      step(mk(T_SINGLE, 4'b1000), 1, 1, 4'd0, 4'd7, 4'd0, 4'd0);
      check("lit_after_tail", direction_out, 4'b0001);

      // Backpressure holds everything.
      step(mk(T_SINGLE, 4'b0010), 1, 1, 4'd0, 4'd0, 4'd0, 4'd0);
      for (int i = 0; i < 3; i++) begin
         step(mk(T_SINGLE, 4'b1000), 1, 0, 4'd0, 4'd0, 4'd0, 4'd0);
         check("lit_bp_ready", ready_out, 1'b0);
         check("lit_bp_dir", direction_out, 4'b0010);
         check("lit_bp_cnt", err_cnt, 8'd0);
      end
      step(mk(T_SINGLE, 4'b1000), 1, 1, 4'd0, 4'd0, 4'd0, 4'd0);
      check("lit_bp_release", direction_out, 4'b0001);
      step('0, 0, 1, 4'd0, 4'd0, 4'd0, 4'd0);
      check("lit_drain_valid", valid_out, 1'b0);

      // Errors and counter saturation.
      step(mk(T_SINGLE, 4'b0011), 1, 1, 4'd0, 4'd0, 4'd0, 4'd0);
      check("lit_range_dir", direction_out, 4'b1111);
      check("lit_range_err", err_out, 1'b1);
      check("lit_cnt1", err_cnt, 8'd1);
      step(mk(T_BODY, 4'b0010), 1, 1, 4'd0, 4'd0, 4'd0, 4'd0);
      check("lit_idle_body", direction_out, 4'b1111);
      check("lit_cnt2", err_cnt, 8'd2);
      for (int i = 0; i < 258; i++)
         step(mk(T_BODY, 4'($urandom)), 1, 1, 4'd0, 4'd0, 4'd0, 4'd0);
      check("lit_cnt_sat", err_cnt, 8'd255);

      // Asynchronous reset in the middle of a packet.
      step(mk(T_HEAD, 4'b1010), 1, 1, 4'd0, 4'd1, 4'd7, 4'd0);
      #2;
      apply_reset();
      check("lit_rst_cnt", err_cnt, 8'd0);
      step(mk(T_TAIL, 4'b1010), 1, 1, 4'd0, 4'd0, 4'd0, 4'd0);
      check("lit_rst_tail_dir", direction_out, 4'b1111);
      check("lit_rst_tail_err", err_out, 1'b1);
      step(mk(T_BODY, 4'b1010), 1, 1, 4'd0, 4'd0, 4'd0, 4'd0);
      check("lit_rst_idle", direction_out, 4'b1111);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 399) == 0)
            apply_reset();
         else
            step(mk(2'($urandom), 4'($urandom)), $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
                 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
